// File: rtl/addsub_pkg.sv
// Shared encodings and sizing for the sequential nibble-serial adder/subtractor.
package addsub_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned NIBBLES   = DEF_WIDTH / 4;
    localparam int unsigned CNT_W     = $clog2(NIBBLES);

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_CALC = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Signed overflow: operands agree in sign but the result sign differs.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla4.sv
// 4-bit carry-lookahead adder slice; purely combinational.
module cla4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [3:0] c;

    always_comb begin
        g    = a & b;
        p    = a ^ b;
        c[0] = ci;
        c[1] = g[0] | (p[0] & ci);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
        co   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);
        s    = p ^ c;
    end

endmodule

// File: rtl/seq_addsub32.sv
// Multi-cycle adder/subtractor: one cla4 slice walks the operands a nibble per clock, LSB first.
module seq_addsub32
    import addsub_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int unsigned Nib  = WIDTH / 4;
    localparam int unsigned CntW = (Nib > 1) ? $clog2(Nib) : 1;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             c_q, c_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;

    logic [CntW+1:0]  bit_idx;
    logic [3:0]       nib_s;
    logic             nib_co;
    logic             last;

    assign bit_idx = {cnt_q, 2'b00};
    assign last    = (cnt_q == CntW'(Nib - 1));

    cla4 u_cla4 (
        .a  (a_q[bit_idx +: 4]),
        .b  (b_q[bit_idx +: 4]),
        .ci (c_q),
        .s  (nib_s),
        .co (nib_co)
    );

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        s_d     = s_q;
        co_d    = co_q;
        ovf_d   = ovf_q;
        done_d  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    // Subtract is a + ~b + 1: invert B here, inject the +1 as carry-in.
                    a_d     = a;
                    b_d     = b ^ {WIDTH{op}};
                    c_d     = op;
                    cnt_d   = '0;
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                s_d[bit_idx +: 4] = nib_s;
                c_d               = nib_co;
                cnt_d             = cnt_q + CntW'(1);
                if (last) begin
                    co_d    = nib_co;
                    ovf_d   = ovf_calc(a_q[WIDTH-1], b_q[WIDTH-1], nib_s[3]);
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            s_q     <= s_d;
            co_q    <= co_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign ovf  = ovf_q;
    assign busy = (state_q == ST_CALC);
    assign done = done_q;

endmodule

// File: tb/tb_seq_addsub32.sv
// Directed self-checking bench for seq_addsub32.
module tb_seq_addsub32;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic        co;
    logic        ovf;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    seq_addsub32 #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .s       (s),
        .co      (co),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts edges from the accepting edge through the edge that raises done; ends at a negedge.
    task automatic wait_done(output int lat, output bit timeout);
        lat = 1;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (busy && done) begin
                checks++;
                errors++;
                $display("FAIL busy_done_overlap: busy=%b done=%b required not both 1", busy, done);
            end
        end
        timeout = !done;
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                          output int lat, output bit timeout);
        @(negedge clk);
        a     = ta;
        b     = tb;
        op    = top;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, timeout);
    endtask

    task automatic check_result(input string name, input logic [31:0] es, input logic eco,
                                input logic eovf, input int lat, input bit timeout);
        checks++;
        if (timeout || lat !== 9) begin
            errors++;
            $display("FAIL %s_latency: got %0d edges timeout=%b, required 9", name, lat, timeout);
        end
        checks++;
        if ({s, co, ovf, busy} !== {es, eco, eovf, 1'b0}) begin
            errors++;
            $display("FAIL %s_result: s=%h co=%b ovf=%b busy=%b, required s=%h co=%b ovf=%b busy=0",
                     name, s, co, ovf, busy, es, eco, eovf);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b1;
        op      = 1'b0;
        a       = 32'h1234_5678;
        b       = 32'h1111_1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({s, co, ovf, busy, done} !== 36'h0) begin
            errors++;
            $display("FAIL reset_hold: s=%h co=%b ovf=%b busy=%b done=%b, required all 0",
                     s, co, ovf, busy, done);
        end
        start   = 1'b0;
        reset_n = 1'b1;
        repeat (5) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
            end
        end
    endtask

    task automatic test_add();
        int lat;
        bit to;
        run_op(32'h0000_000F, 32'h0000_0001, 1'b0, lat, to);
        check_result("add_basic", 32'h0000_0010, 1'b0, 1'b0, lat, to);
        run_op(32'h1234_5678, 32'h1111_1111, 1'b0, lat, to);
        check_result("add_mixed", 32'h2345_6789, 1'b0, 1'b0, lat, to);
    endtask

    task automatic test_add_carry();
        int lat;
        bit to;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, to);
        check_result("add_carry", 32'h0000_0000, 1'b1, 1'b0, lat, to);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, lat, to);
        check_result("add_ovf", 32'h8000_0000, 1'b0, 1'b1, lat, to);
    endtask

    task automatic test_sub();
        int lat;
        bit to;
        run_op(32'd5, 32'd7, 1'b1, lat, to);
        check_result("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, lat, to);
        run_op(32'h8000_0000, 32'h0000_0001, 1'b1, lat, to);
        check_result("sub_ovf", 32'h7FFF_FFFF, 1'b1, 1'b1, lat, to);
        run_op(32'h0000_0100, 32'h0000_0001, 1'b1, lat, to);
        check_result("sub_plain", 32'h0000_00FF, 1'b1, 1'b0, lat, to);
    endtask

    task automatic test_handshake();
        int lat;
        bit to;
        @(negedge clk);
        a     = 32'h0000_1000;
        b     = 32'h0000_0234;
        op    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        a     = 32'hDEAD_BEEF;
        b     = 32'h0BAD_F00D;
        op    = 1'b1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat   = 5;
        while (!done && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        to = !done;
        check_result("ignore_mid_start", 32'h0000_1234, 1'b0, 1'b0, lat, to);
    endtask

    task automatic test_back_to_back();
        int lat;
        bit to;
        run_op(32'h0000_00AA, 32'h0000_0011, 1'b0, lat, to);
        check_result("b2b_first", 32'h0000_00BB, 1'b0, 1'b0, lat, to);
        a     = 32'd3;
        b     = 32'd4;
        op    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0 || s !== 32'h0000_00BB) begin
            errors++;
            $display("FAIL b2b_accept: busy=%b done=%b s=%h, required busy=1 done=0 s=000000bb",
                     busy, done, s);
        end
        wait_done(lat, to);
        check_result("b2b_second", 32'h0000_0007, 1'b0, 1'b0, lat, to);
    endtask

    task automatic test_reset_mid();
        bit seen_done;
        @(negedge clk);
        a     = 32'h1111_1111;
        b     = 32'h2222_2222;
        op    = 1'b0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({s, co, ovf, busy, done} !== 36'h0) begin
            errors++;
            $display("FAIL reset_mid: s=%h co=%b ovf=%b busy=%b done=%b, required all 0",
                     s, co, ovf, busy, done);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        seen_done = 1'b0;
        repeat (15) begin
            @(posedge clk);
            @(negedge clk);
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_no_done: activity seen=%b, required 0", seen_done);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 1'b0;
        a       = '0;
        b       = '0;
        test_reset();
        test_add();
        test_add_carry();
        test_sub();
        test_handshake();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
